// File: rtl/axi_lite_rd_decoder.sv
// 1:N AXI4-Lite read-path decoder: routes one master's AR to an address-matched
// slave, passes the R beat straight back, and answers unmapped reads with DECERR.

module stdreg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  // NOTE: sequential state is only ever assigned with <= so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   o_q <= RESET_VAL;
    else if (i_wen) o_q <= i_d;
  end
endmodule

module axi_lite_rd_decoder #(
  parameter int                              M_COUNT    = 2,
  parameter int                              ADDR_WIDTH = 32,
  parameter int                              DATA_WIDTH = 32,
  parameter logic [M_COUNT*ADDR_WIDTH-1:0]   M_BASE     = '0,
  parameter logic [M_COUNT*ADDR_WIDTH-1:0]   M_MASK     = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [ADDR_WIDTH-1:0]         s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [M_COUNT*ADDR_WIDTH-1:0] m_araddr,
  output logic [M_COUNT-1:0]            m_arvalid,
  input  logic [M_COUNT-1:0]            m_arready,
  input  logic [M_COUNT*DATA_WIDTH-1:0] m_rdata,
  input  logic [M_COUNT*2-1:0]          m_rresp,
  input  logic [M_COUNT-1:0]            m_rvalid,
  output logic [M_COUNT-1:0]            m_rready
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              state_raw;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic                    ar_fire;
  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic                    sel_arready;
  logic                    sel_rvalid;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [1:0]              sel_rresp;

  stdreg #(.WIDTH(2), .RESET_VAL(2'(IDLE))) u_state_reg (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wen(1'b1), .i_d(state_d), .o_q(state_raw)
  );
  stdreg #(.WIDTH(SEL_W)) u_sel_reg (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wen(1'b1), .i_d(sel_d), .o_q(sel_q)
  );
  stdreg #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wen(1'b1), .i_d(addr_d), .o_q(addr_q)
  );

  assign state_q   = state_t'(state_raw);
  assign s_arready = i_rst_n && (state_q == IDLE);
  assign ar_fire   = s_arvalid && s_arready;
  assign m_araddr  = {M_COUNT{addr_q}};

  // Walk from the top slot down so the lowest matching index wins on overlap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if ((s_araddr & M_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (M_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & M_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rdata   = '0;
    sel_rresp   = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_arready = m_arready[i];
        sel_rvalid  = m_rvalid[i];
        sel_rdata   = m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_rresp   = m_rresp[i*2 +: 2];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < M_COUNT; i++) begin
      m_arvalid[i] = (state_q == ADDR) && (sel_q == SEL_W'(i));
      m_rready[i]  = (state_q == DATA) && (sel_q == SEL_W'(i)) && s_rready;
    end
  end

  always_comb begin
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_rresp  = '0;
    case (state_q)
      DATA: begin
        s_rvalid = sel_rvalid;
        s_rdata  = sel_rdata;
        s_rresp  = sel_rresp;
      end
      ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (ar_fire) begin
        addr_d = s_araddr;
        if (hit) begin
          sel_d   = hit_idx;
          state_d = ADDR;
        end else begin
          state_d = ERR;
        end
      end
      ADDR:    if (sel_arready)             state_d = DATA;
      DATA:    if (sel_rvalid && s_rready)  state_d = IDLE;
      ERR:     if (s_rready)                state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rd_decoder.sv
// Randomized transaction-level bench for axi_lite_rd_decoder: the bench plays
// master and both slaves and predicts every beat from the address map.

module tb_axi_lite_rd_decoder;

  localparam int M_COUNT = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam logic [M_COUNT*AW-1:0] BASE = {32'h1000_0000, 32'h8000_0000};
  localparam logic [M_COUNT*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000};

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [AW-1:0]         s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [DW-1:0]         s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [M_COUNT*AW-1:0] m_araddr;
  logic [M_COUNT-1:0]    m_arvalid;
  logic [M_COUNT-1:0]    m_arready;
  logic [M_COUNT*DW-1:0] m_rdata;
  logic [M_COUNT*2-1:0]  m_rresp;
  logic [M_COUNT-1:0]    m_rvalid;
  logic [M_COUNT-1:0]    m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  axi_lite_rd_decoder #(
    .M_COUNT(M_COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .M_BASE(BASE), .M_MASK(MASK)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Address map: top nibble 0x8 is slot 0, 0x1 is slot 1, anything else unmapped.
  function automatic int ref_slot(input logic [AW-1:0] addr);
    if ((addr >> 28) == 32'h8) return 0;
    if ((addr >> 28) == 32'h1) return 1;
    return -1;
  endfunction

  task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                         input int rr_dly);
    int                 k;
    logic [DW-1:0]      data;
    logic [1:0]         resp;
    logic [M_COUNT-1:0] onehot;
    logic [M_COUNT-1:0] other;
    logic               valid;
    k      = ref_slot(addr);
    data   = $urandom;
    resp   = 2'($urandom_range(0, 2));
    onehot = (k >= 0) ? M_COUNT'(1 << k) : '0;
    other  = ~onehot;

    s_araddr  = addr;
    s_arvalid = 1'b1;
    #1 check("ar_accept", s_arready, 1);
    tick();
    // A stray AR held on the bus while busy must be neither accepted nor latched.
    s_arvalid = 1'($urandom_range(0, 1));
    s_araddr  = $urandom;

    if (k < 0) begin
      for (int c = 0; c <= rr_dly; c++) begin
        s_rready = (c == rr_dly);
        if (c == rr_dly) s_arvalid = 1'b0;
        #1;
        check("err_arvalid", m_arvalid, 0);
        check("err_arready", s_arready, 0);
        check("err_rvalid", s_rvalid, 1);
        check("err_rresp", s_rresp, 2'b11);
        check("err_rdata", s_rdata, 0);
        tick();
      end
      s_rready = 1'b0;
    end else begin
      for (int c = 0; c <= ar_dly; c++) begin
        m_arready = ((c == ar_dly) ? onehot : '0) | (M_COUNT'($urandom) & other);
        #1;
        check("addr_arvalid", m_arvalid, onehot);
        check("addr_araddr", m_araddr, {M_COUNT{addr}});
        check("addr_arready", s_arready, 0);
        check("addr_rvalid", s_rvalid, 0);
        check("addr_rready", m_rready, 0);
        tick();
      end
      m_arready = '0;
      for (int c = 0; c <= r_dly + rr_dly; c++) begin
        valid = (c >= r_dly);
        if (c == r_dly + rr_dly) begin
          s_rready  = 1'b1;
          s_arvalid = 1'b0;
        end else begin
          s_rready = valid ? 1'b0 : 1'($urandom_range(0, 1));
        end
        m_rvalid = (valid ? onehot : '0) | (M_COUNT'($urandom) & other);
        for (int i = 0; i < M_COUNT; i++) begin
          m_rdata[i*DW +: DW] = (i == k) ? (valid ? data : $urandom) : 32'h1234;
          m_rresp[i*2 +: 2]   = (i == k) ? resp : 2'($urandom);
        end
        #1;
        check("data_arvalid", m_arvalid, 0);
        check("data_arready", s_arready, 0);
        check("data_rvalid", s_rvalid, valid);
        check("data_rready", m_rready, s_rready ? onehot : '0);
        if (valid) begin
          check("data_rdata", s_rdata, data);
          check("data_rresp", s_rresp, resp);
        end
        tick();
      end
      m_rvalid = '0;
      s_rready = 1'b0;
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    i_rst_n   = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rvalid  = '0;
    tick();
    tick();
    check("rst_arready", s_arready, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_rvalid", s_rvalid, 0);
    i_rst_n = 1'b1;
    #1 check("post_rst_arready", s_arready, 1);
    tick();

    do_read(32'h8000_0010, 0, 1, 0);
    do_read(32'h1000_0004, 3, 0, 2);
    do_read(32'h4000_0000, 0, 0, 2);
    do_read(32'h8000_0100, 1, 2, 1);

    // Abandon a read while its AR is outstanding on slot 0.
    s_araddr  = 32'h8000_0000;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    #1 check("midrst_arvalid_before", m_arvalid, 2'b01);
    i_rst_n = 1'b0;
    #1 check("midrst_arready", s_arready, 0);
    tick();
    check("midrst_arvalid", m_arvalid, 0);
    check("midrst_rvalid", s_rvalid, 0);
    check("midrst_rready", m_rready, 0);
    i_rst_n = 1'b1;
    #1 check("midrst_release_arready", s_arready, 1);
    tick();
    do_read(32'h8000_0000, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: a[31:28] = 4'h8;
        1: a[31:28] = 4'h1;
        default: ;
      endcase
      do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_decoder.md
Name: axi_lite_rd_decoder

Overview:
- 1:N AXI4-Lite read-path decoder. It routes a single upstream master's AR request to one of M_COUNT downstream slaves by address, and routes that slave's R beat back.
- It is the slave-side counterpart of the N:1 arbiter mux on the bus: the arbiter funnels many masters onto one port, and this block fans that port out to the peripheral slaves.
- It allows one outstanding transaction and answers unmapped addresses internally with DECERR.

Parameters:
- M_COUNT, 2, number of downstream slave ports (at least 1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- M_BASE, {M_COUNT{32'h0}}, packed base addresses; slot i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- M_MASK, {M_COUNT{32'h0}}, packed address masks, same packing as M_BASE. Slot i matches when (addr & M_MASK[i]) == (M_BASE[i] & M_MASK[i]).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- s_araddr  in  ADDR_WIDTH  upstream read address.
- s_arvalid  in  1  upstream AR valid.
- s_arready  out  1  upstream AR ready.
- s_rdata  out  DATA_WIDTH  upstream read data.
- s_rresp  out  2  upstream read response.
- s_rvalid  out  1  upstream R valid.
- s_rready  in  1  upstream R ready.
- m_araddr  out  M_COUNT*ADDR_WIDTH  downstream addresses, packed per port.
- m_arvalid  out  M_COUNT  downstream AR valid, one bit per port.
- m_arready  in  M_COUNT  downstream AR ready.
- m_rdata  in  M_COUNT*DATA_WIDTH  downstream read data, packed per port.
- m_rresp  in  M_COUNT*2  downstream responses, packed per port.
- m_rvalid  in  M_COUNT  downstream R valid.
- m_rready  out  M_COUNT  downstream R ready.

Behaviour:
- State and data registers are built on stdreg (i_wen = 1). State is IDLE, ADDR, DATA, ERR; registers are sel_reg [$clog2(M_COUNT) or 1 bit] and addr_reg [ADDR_WIDTH].
- Reset (i_rst_n = 0 at a clock edge):
  - state goes to IDLE; sel_reg and addr_reg go to 0.
  - All of m_arvalid, m_rready and s_rvalid are 0. s_arready is 0 during the reset cycle.
  - Reset mid-transaction abandons the transaction; no response is generated.
- IDLE:
  - s_arready = 1.
  - On s_arvalid && s_arready: latch addr_reg = s_araddr and decode it.
  - Decode uses the lowest-index matching slot (LSB priority), so overlapping windows resolve to the lowest index.
  - On a hit, latch sel_reg and go to ADDR. On no hit, go to ERR.
- ADDR:
  - s_arready = 0.
  - m_arvalid[sel_reg] = 1; all other m_arvalid bits are 0.
  - Every m_araddr slot carries addr_reg.
  - Hold until m_arready[sel_reg], then go to DATA. m_arvalid must stay stable until that handshake.
- DATA (combinational pass-through, zero added latency on R):
  - s_rvalid = m_rvalid[sel_reg]; s_rdata and s_rresp come from slot sel_reg.
  - m_rready[sel_reg] = s_rready; all other m_rready bits are 0.
  - On m_rvalid[sel_reg] && s_rready, go to IDLE.
- ERR:
  - s_rvalid = 1, s_rresp = 2'b11 (DECERR), s_rdata = 0.
  - On s_rready, go to IDLE. No downstream port is touched.
- Outside DATA/ERR, s_rvalid = 0 and s_rdata/s_rresp = 0.
- m_rvalid from a non-selected port, or in any state other than DATA, is ignored: m_rready stays 0 and the signal has no effect.
- Latency:
  - AR accepted at cycle 0 gives m_arvalid at cycle 1.
  - An R beat presented by the slave is visible upstream in the same cycle.
  - The earliest next AR acceptance is the cycle after the R handshake, so best-case throughput is 1 transaction per 3 cycles.
  - An ERR response appears at cycle 1 after AR acceptance.
- s_arready is never 1 outside IDLE, which guarantees a single outstanding transaction.
- An all-zero mask matches every address. This is legal and typically used for a catch-all highest-index slot.

Test Plan:
- Setup for all scenarios: M_COUNT=2, M_BASE={32'h1000_0000, 32'h8000_0000} (slot0 = 0x8000_0000, slot1 = 0x1000_0000), M_MASK={32'hF000_0000, 32'hF000_0000}.
- Hit, slot 0: s_araddr=0x8000_0010 accepted at cycle 0; m_arready[0]=1 at cycle 1; at cycle 3 slot 0 drives m_rvalid[0]=1, m_rdata=0xDEADBEEF, rresp=0 with s_rready=1 -> m_arvalid=2'b01 at cycle 1, m_araddr slot0=0x8000_0010, same-cycle s_rvalid=1 with s_rdata=0xDEADBEEF, s_arready=1 again at cycle 4.
- Hit, slot 1 with backpressure: s_araddr=0x1000_0004; hold m_arready[1]=0 for 3 cycles, then 1; hold s_rready=0 for 2 cycles while m_rvalid[1]=1 -> m_arvalid=2'b10 stable throughout, m_rready[1] follows s_rready, m_rready[0]=0, single R handshake.
- Unmapped: s_araddr=0x4000_0000 -> no m_arvalid ever; at cycle 1 s_rvalid=1, s_rresp=2'b11, s_rdata=0; held until s_rready; then IDLE.
- Stray response: during a slot 0 transaction in DATA, assert m_rvalid[1]=1 with rdata=0x1234 -> m_rready[1]=0 and s_rdata still equals slot 0 data.
- Reset mid-op: pull i_rst_n=0 while in ADDR with m_arvalid[0]=1 -> next cycle m_arvalid=0, s_rvalid=0; after reset release, s_arready=1 and a new read to 0x8000_0000 completes normally.
- Back-to-back: two reads issued with s_arvalid held high -> the second AR is accepted only in the cycle after the first R handshake; ordering is preserved.
